// File: rtl/spi_write_bridge_if.sv
// SPI write bridge bus: the three asynchronous SPI pins coming in from the
// host MCU and the write port going out to the output engine.
interface spi_write_bridge_if #(
    parameter int ADDR_WIDTH = 13
);
    logic                  spi_sck;
    logic                  spi_cs_n;
    logic                  spi_mosi;
    logic [15:0]           spi_data;
    logic [ADDR_WIDTH-1:0] spi_address;
    logic                  spi_write_strobe;
    logic                  frame_active;
    logic                  frame_done;
    logic                  overflow;

    // The bridge itself: receives SPI, produces memory writes.
    modport slave (
        input  spi_sck,
        input  spi_cs_n,
        input  spi_mosi,
        output spi_data,
        output spi_address,
        output spi_write_strobe,
        output frame_active,
        output frame_done,
        output overflow
    );

    // The host side: drives SPI, observes the write port.
    modport master (
        output spi_sck,
        output spi_cs_n,
        output spi_mosi,
        input  spi_data,
        input  spi_address,
        input  spi_write_strobe,
        input  frame_active,
        input  frame_done,
        input  overflow
    );
endinterface

// File: rtl/spi_write_bridge.sv
// SPI slave (mode 0, MSB first) that turns frames of one 16-bit header plus
// N 16-bit data words into single-cycle writes with an auto-incrementing
// address. SCK/CS/MOSI are asynchronous to clk and synchronised here, so SCK
// must run at clk/8 or slower.
module spi_write_bridge #(
    parameter int ADDR_WIDTH  = 13,
    parameter int MAX_ADDRESS = 335,
    parameter int SYNC_STAGES = 2     // must be >= 2
) (
    input  logic                  clk,
    input  logic                  rst,      // asynchronous, active low
    spi_write_bridge_if.slave     io_bus
);

    localparam int                    WORD_W     = 16;
    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR_L = ADDR_WIDTH'(MAX_ADDRESS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2,
        S_SKIP   = 2'd3
    } state_t;

    // Address pointer advance that sticks at all-ones instead of wrapping,
    // so a long frame can never alias back onto low addresses.
    function automatic logic [ADDR_WIDTH-1:0] f_sat_inc(input logic [ADDR_WIDTH-1:0] a);
        if (&a) begin
            return a;
        end
        return a + ADDR_WIDTH'(1);
    endfunction

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_cs_armed;

    logic w_sck;
    logic w_cs;
    logic w_mosi;
    logic w_sck_rise;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_cs_fall_ok;
    logic w_sync_valid;

    assign w_sck        = r_sck_sync[SYNC_STAGES-1];
    assign w_cs         = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise   = w_sck & ~r_sck_d;
    assign w_cs_rise    = w_cs & ~r_cs_d;
    assign w_cs_fall    = ~w_cs & r_cs_d;
    // The last synchroniser stage only holds a real pin sample once the
    // reset preset has been flushed through the chain.
    assign w_sync_valid = r_fill[SYNC_STAGES-1];
    // A CS fall only starts a frame after CS has really been seen high.
    // Coming out of reset with CS already low, the preset-to-low transition
    // is not a real fall, so the rest of that frame is ignored.
    assign w_cs_fall_ok = w_cs_fall & r_cs_armed;

    // Synchronise the SPI pins and keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b1;
            r_fill      <= '0;
            r_cs_armed  <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], io_bus.spi_sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], io_bus.spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], io_bus.spi_mosi};
            r_sck_d     <= w_sck;
            r_cs_d      <= w_cs;
            r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_cs_armed  <= r_cs_armed | (w_sync_valid & w_cs);
        end
    end

    // ------------------------------------------------------------------
    // Bit assembly
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_bit_cnt;
    logic [WORD_W-2:0]   r_shift;
    logic [WORD_W-1:0]   r_word;
    logic                r_word_vld;
    logic [WORD_W-1:0]   w_word_next;
    logic                w_bit_en;

    assign w_word_next = {r_shift, w_mosi};
    // CS low and a frame in progress; a CS edge in the same cycle wins.
    assign w_bit_en    = w_sck_rise & ~w_cs & ~w_cs_fall_ok & (r_state != S_IDLE);

    // Shift in MOSI on each SCK rise and flag every completed 16-bit word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt  <= 4'd0;
            r_shift    <= '0;
            r_word     <= '0;
            r_word_vld <= 1'b0;
        end else begin
            r_word_vld <= 1'b0;
            if (w_cs_fall_ok || w_cs_rise) begin
                r_bit_cnt <= 4'd0;
            end else if (w_bit_en) begin
                r_shift   <= w_word_next[WORD_W-2:0];
                r_bit_cnt <= r_bit_cnt + 4'd1;
                if (r_bit_cnt == 4'd15) begin
                    r_word     <= w_word_next;
                    r_word_vld <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic                  r_frame_active;
    logic                  w_hdr_load;
    logic                  w_word_accept;
    logic                  w_frame_end;
    logic                  w_frame_abort;

    // Hold the current frame state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Decode CS edges and completed words into state moves and write actions.
    always_comb begin
        w_state_next  = r_state;
        w_hdr_load    = 1'b0;
        w_word_accept = 1'b0;
        w_frame_end   = 1'b0;
        w_frame_abort = 1'b0;
        if (w_cs_fall_ok) begin
            // A fall without a preceding rise is treated as a fresh frame;
            // the old one is dropped silently.
            w_state_next  = S_HEADER;
            w_frame_abort = r_frame_active;
        end else if (w_cs_rise) begin
            w_state_next  = S_IDLE;
            w_frame_end   = r_frame_active;
            // A word that completed just before CS rose is still written.
            w_word_accept = (r_state == S_DATA) && r_word_vld;
        end else begin
            case (r_state)
                S_HEADER: begin
                    if (r_word_vld) begin
                        if (r_word[WORD_W-1]) begin
                            w_hdr_load   = 1'b1;
                            w_state_next = S_DATA;
                        end else begin
                            w_state_next = S_SKIP;
                        end
                    end
                end
                S_DATA: begin
                    w_word_accept = r_word_vld;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_addr_ptr;
    logic [WORD_W-1:0]     r_spi_data;
    logic [ADDR_WIDTH-1:0] r_spi_address;
    logic                  r_write_strobe;
    logic                  r_frame_done;
    logic                  r_overflow;

    // Register writes, address pointer, frame status and the sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr_ptr     <= '0;
            r_spi_data     <= '0;
            r_spi_address  <= '0;
            r_write_strobe <= 1'b0;
            r_frame_active <= 1'b0;
            r_frame_done   <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_write_strobe <= 1'b0;
            r_frame_done   <= w_frame_end;
            if (w_hdr_load) begin
                r_addr_ptr     <= r_word[ADDR_WIDTH-1:0];
                r_overflow     <= 1'b0;
                r_frame_active <= 1'b1;
            end
            if (w_word_accept) begin
                r_spi_data <= r_word;
                if (r_addr_ptr <= MAX_ADDR_L) begin
                    r_spi_address  <= r_addr_ptr;
                    r_write_strobe <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
                r_addr_ptr <= f_sat_inc(r_addr_ptr);
            end
            if (w_frame_end || w_frame_abort) begin
                r_frame_active <= 1'b0;
            end
        end
    end

    assign io_bus.spi_data         = r_spi_data;
    assign io_bus.spi_address      = r_spi_address;
    assign io_bus.spi_write_strobe = r_write_strobe;
    assign io_bus.frame_active     = r_frame_active;
    assign io_bus.frame_done       = r_frame_done;
    assign io_bus.overflow         = r_overflow;

endmodule

// File: tb/tb_spi_write_bridge.sv
// Bench for spi_write_bridge: directed frames plus random frames, checked
// against a frame-level model of the expected writes.
module tb_spi_write_bridge;

    localparam int AW   = 13;
    localparam int MAXA = 335;
    localparam int AMAX = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_write_bridge_if #(.ADDR_WIDTH(AW)) bus ();

    spi_write_bridge #(
        .ADDR_WIDTH  (AW),
        .MAX_ADDRESS (MAXA),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    wr_t         exp_q[$];
    int          seen_a[$];
    int          seen_d[$];
    int          fd_count = 0;
    int          last_addr = 0;
    bit          exp_ovf = 1'b0;
    int          exp_data = 0;
    logic [15:0] wbuf[8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Shift nbits of w out MSB first at SCK = clk/8. When the 16th bit of a
    // data word in a write frame rises, the model records what must happen.
    task automatic send_word(input logic [15:0] w, input int nbits, input bit is_data,
                             input bit wr_frame, input int ptr);
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = w[15-i];
            tick(4);
            bus.spi_sck = 1'b1;
            if (i == 15 && is_data && wr_frame) begin
                exp_data = int'(w);
                if (ptr <= MAXA) exp_q.push_back('{cyc, ptr, int'(w)});
                else exp_ovf = 1'b1;
            end
            tick(4);
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [15:0] hdr, input int nw, input int partial);
        bit wr;
        int fd0;
        int ptr;
        wr = hdr[15];
        bus.spi_cs_n = 1'b0;
        tick(6);
        send_word(hdr, 16, 1'b0, 1'b0, 0);
        if (wr) exp_ovf = 1'b0;
        for (int k = 0; k < nw; k++) begin
            ptr = int'(hdr[AW-1:0]) + k;
            if (ptr > AMAX) ptr = AMAX;
            send_word(wbuf[k], 16, 1'b1, wr, ptr);
        end
        if (partial > 0) send_word(16'($urandom), partial, 1'b1, wr, 0);
        tick(8);
        check("frame_active_in_frame", int'(bus.frame_active), int'(wr));
        fd0 = fd_count;
        bus.spi_cs_n = 1'b1;
        tick(10);
        check("frame_done_count", fd_count - fd0, int'(wr));
        check("frame_active_after", int'(bus.frame_active), 0);
        check("overflow", int'(bus.overflow), int'(exp_ovf));
        check("data_after_frame", int'(bus.spi_data), exp_data);
        check("missing_strobes", exp_q.size(), 0);
        exp_q.delete();
        tick(4);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobe"}, int'(bus.spi_write_strobe), 0);
        check({tag, "_data"}, int'(bus.spi_data), 0);
        check({tag, "_addr"}, int'(bus.spi_address), 0);
        check({tag, "_active"}, int'(bus.frame_active), 0);
        check({tag, "_done"}, int'(bus.frame_done), 0);
        check({tag, "_ovf"}, int'(bus.overflow), 0);
    endtask

    function automatic int seen_at(input int idx, input bit want_addr);
        if (idx >= seen_a.size()) return -1;
        return want_addr ? seen_a[idx] : seen_d[idx];
    endfunction

    // Compare process: every cycle outside reset, a strobe must match the
    // oldest expected write (address, data, latency) and the address must
    // otherwise hold its last written value.
    initial begin
        wr_t e;
        bit  fd_prev;
        fd_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_addr = 0;
                fd_prev = 1'b0;
            end else begin
                if (bus.spi_write_strobe) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", int'(bus.spi_address), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("strobe_addr", int'(bus.spi_address), e.addr);
                        check("strobe_data", int'(bus.spi_data), e.data);
                        check("strobe_latency_3to5", int'((cyc - e.cyc) >= 3 && (cyc - e.cyc) <= 5), 1);
                        seen_a.push_back(int'(bus.spi_address));
                        seen_d.push_back(int'(bus.spi_data));
                        last_addr = e.addr;
                    end
                end else begin
                    check("addr_hold", int'(bus.spi_address), last_addr);
                end
                if (bus.frame_done) begin
                    if (fd_prev) check("frame_done_one_clk", 2, 1);
                    else fd_count++;
                end
                fd_prev = bus.frame_done;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int base;
        int fd0;
        bus.spi_sck  = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        rst = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst = 1'b1;
        tick(6);

        // Basic three-word write frame.
        wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD; wbuf[2] = 16'h0001;
        base = seen_a.size();
        run_frame(16'h8000, 3, 0);
        check("t1_count", seen_a.size() - base, 3);
        check("t1_a0", seen_at(base, 1'b1), 0);
        check("t1_d0", seen_at(base, 1'b0), 16'h1234);
        check("t1_a1", seen_at(base + 1, 1'b1), 1);
        check("t1_d1", seen_at(base + 1, 1'b0), 16'hABCD);
        check("t1_a2", seen_at(base + 2, 1'b1), 2);
        check("t1_d2", seen_at(base + 2, 1'b0), 16'h0001);
        check("t1_ovf", int'(bus.overflow), 0);

        // Crossing MAX_ADDRESS: third word dropped, overflow sticks.
        wbuf[0] = 16'h0AAA; wbuf[1] = 16'h0BBB; wbuf[2] = 16'h0CCC;
        base = seen_a.size();
        run_frame(16'h814E, 3, 0);
        check("t2_count", seen_a.size() - base, 2);
        check("t2_a0", seen_at(base, 1'b1), 334);
        check("t2_a1", seen_at(base + 1, 1'b1), 335);
        check("t2_ovf", int'(bus.overflow), 1);
        check("t2_dropped_data", int'(bus.spi_data), 16'h0CCC);
        wbuf[0] = 16'h0F0F;
        run_frame(16'h8000, 1, 0);
        check("t2_ovf_cleared", int'(bus.overflow), 0);

        // Non-write header: everything ignored.
        wbuf[0] = 16'h7777; wbuf[1] = 16'h8888;
        base = seen_a.size();
        run_frame(16'h0005, 2, 0);
        check("t3_count", seen_a.size() - base, 0);

        // Partial trailing word discarded.
        wbuf[0] = 16'h5555;
        base = seen_a.size();
        run_frame(16'h8010, 1, 9);
        check("t4_count", seen_a.size() - base, 1);
        check("t4_a0", seen_at(base, 1'b1), 16'h10);
        check("t4_d0", seen_at(base, 1'b0), 16'h5555);

        // Pointer saturates at all-ones: every word dropped.
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333;
        base = seen_a.size();
        run_frame(16'h9FFE, 3, 0);
        check("sat_count", seen_a.size() - base, 0);
        check("sat_ovf", int'(bus.overflow), 1);

        // Reset in the middle of a data word, CS held low afterwards.
        bus.spi_cs_n = 1'b0;
        tick(6);
        send_word(16'h8000, 16, 1'b0, 1'b0, 0);
        send_word(16'hC3C3, 8, 1'b1, 1'b0, 0);
        rst = 1'b0;
        tick(2);
        check_all_zero("midrst");
        exp_ovf = 1'b0;
        exp_data = 0;
        rst = 1'b1;
        tick(2);
        base = seen_a.size();
        send_word(16'h8FFF, 16, 1'b1, 1'b0, 0);
        send_word(16'h8001, 8, 1'b1, 1'b0, 0);
        fd0 = fd_count;
        bus.spi_cs_n = 1'b1;
        tick(10);
        check("midrst_no_done", fd_count - fd0, 0);
        check("midrst_no_strobe", seen_a.size() - base, 0);
        check("midrst_active", int'(bus.frame_active), 0);
        tick(4);
        wbuf[0] = 16'hFFFF;
        run_frame(16'h8003, 1, 0);
        check("t5_count", seen_a.size() - base, 1);
        check("t5_a0", seen_at(base, 1'b1), 3);
        check("t5_d0", seen_at(base, 1'b0), 16'hFFFF);

        // Random frames.
        for (int f = 0; f < 25; f++) begin
            int          a;
            int          nw;
            int          pb;
            logic [15:0] h;
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(0, MAXA);
                1:       a = $urandom_range(328, 340);
                2:       a = $urandom_range(AMAX - 3, AMAX);
                default: a = $urandom_range(0, AMAX);
            endcase
            h[15]    = ($urandom_range(0, 3) != 0);
            h[14:13] = 2'($urandom);
            h[12:0]  = 13'(a);
            nw = $urandom_range(0, 4);
            pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
            for (int k = 0; k < nw; k++) wbuf[k] = 16'($urandom);
            run_frame(h, nw, pb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_write_bridge.md
Name: spi_write_bridge

Overview:
- SPI slave that receives pixel/channel data from the host MCU and turns it into single-cycle memory writes (data, address, strobe).
- Sits directly upstream of the ICND2110 output engine and drives its spi_data / spi_address / spi_write_strobe inputs.
- Each frame is one 16-bit header word followed by N 16-bit data words, with the address auto-incremented per word.
- SCK, CS and MOSI are asynchronous to clk and are synchronised inside the block.

Parameters:
- ADDR_WIDTH, 13, width of spi_address.
- MAX_ADDRESS, 335, highest writable channel index (28 chips x 12 channels - 1).
- SYNC_STAGES, 2, synchroniser flops on sck/cs_n/mosi (minimum 2).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- spi_sck  input  1  SPI clock, mode 0; data sampled on the rising edge.
- spi_cs_n  input  1  SPI chip select, active low.
- spi_mosi  input  1  SPI data in, MSB first.
- spi_data  output  16  write data.
- spi_address  output  ADDR_WIDTH  write address.
- spi_write_strobe  output  1  one-clk write pulse.
- frame_active  output  1  high while a frame with a valid write header is in progress.
- frame_done  output  1  one-clk pulse when CS rises after a write frame.
- overflow  output  1  sticky flag: a data word addressed beyond MAX_ADDRESS was dropped. Cleared by the next write header.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state IDLE, bit counter 0, shift register 0, synchronisers cleared (cs_n sync preset to 1).
- Input conditioning:
  - sck, cs_n and mosi each pass through SYNC_STAGES flops, then one edge-detect flop.
  - The SCK rising edge is detected on the synchronised signal; mosi is sampled from the same synchronised stage.
  - SCK frequency must be <= clk/8.
- Bit counter: 4 bits, incremented on each detected SCK rise while CS is low. Shift register: shift left, mosi into bit 0.
- State IDLE:
  - CS falling edge -> HEADER, bit counter cleared.
- State HEADER:
  - On the 16th bit, inspect the header word.
  - bit15=1 (write): load addr_ptr <= header[ADDR_WIDTH-1:0], clear overflow, frame_active <= 1, go to DATA.
  - bit15=0: go to SKIP.
  - Header bits 14:13 are reserved and ignored.
- State DATA:
  - On each completed 16-bit word: spi_data <= word.
  - If addr_ptr <= MAX_ADDRESS: spi_address <= addr_ptr and spi_write_strobe=1 for exactly one clk.
  - Otherwise: no strobe and overflow <= 1.
  - addr_ptr increments after every word in both cases, saturating at all-ones (no wrap to 0).
  - spi_data and spi_address hold their values between strobes.
- State SKIP:
  - Ignore all bits until CS rises; no outputs change.
- CS rising edge in any state:
  - Discard any partial word; no strobe for it.
  - Return to IDLE, clear the bit counter.
  - If frame_active: frame_done pulses for 1 clk and frame_active <= 0.
- Latency: spi_write_strobe asserts on clk edge SYNC_STAGES+2 after the 16th SCK rise reaches the pin; the metastability window adds +1 clk.
- Simultaneous SCK rise and CS rise in the same synchronised cycle: CS wins and the bit is discarded.
- CS falling while not in IDLE (glitch or missed rise): treated as a new frame. Go to HEADER and clear the counter; frame_active is cleared without a frame_done pulse.
- Reset mid-frame: immediate return to reset values. The remainder of that frame is treated as SKIP until CS rises, because no CS fall has been seen.

Test Plan:
- Write header 0x8000, then words 0x1234, 0xABCD, 0x0001 at SCK=clk/8 -> three strobes: (addr 0, 0x1234), (1, 0xABCD), (2, 0x0001); frame_done pulses once after CS rises; overflow=0.
- Header 0x814E (addr 334), then 3 words -> strobes at addr 334 and 335 only; third word dropped; overflow=1. A next frame with header 0x8000 clears overflow.
- Header 0x0005 (read/ignore), then 2 words -> no strobes, frame_active stays 0, no frame_done.
- Header 0x8010, then 1 full word 0x5555, then 9 bits and CS rises -> exactly one strobe (addr 0x10, 0x5555); partial word discarded; next frame starts clean at HEADER.
- rst pulled low after 8 bits of a data word, released, CS held low for 24 more bits -> no strobes; all outputs 0 during reset; the following CS cycle with header 0x8003 and word 0xFFFF gives a strobe at addr 3.
- Latency check: SCK=clk/8, SYNC_STAGES=2 -> strobe on clk edge 4 (±1) after the 16th data-bit SCK rise; exactly one clk high.
